// File: rtl/avalon_nn_ctrl_interface.sv
`default_nettype none
// ============================================================================
// Module   : avalon_nn_ctrl_interface
// Brief    : Avalon-MM register front end sequencing one NN inference per START
// Revision : 1.0 - initial release
// ============================================================================
module avalon_nn_ctrl_interface #(
    parameter int N_IN    = 64,
    parameter int N_OUT   = 8,
    parameter int AW      = 7,
    parameter int TIMEOUT = 4096
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  AVL_READ,
    input  logic                  AVL_WRITE,
    input  logic                  AVL_CS,
    input  logic [3:0]            AVL_BYTE_EN,
    input  logic [AW-1:0]         AVL_ADDR,
    input  logic [31:0]           AVL_WRITEDATA,
    output logic [31:0]           AVL_READDATA,
    output logic                  IRQ,
    output logic [32*N_IN-1:0]    NN_X,
    output logic                  NN_START,
    input  logic [32*N_OUT-1:0]   NN_Y,
    input  logic                  NN_DONE
);
    localparam int XIW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int YIW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int TCW = $clog2(TIMEOUT);
    localparam logic [31:0]    c_X_BASE = 32'd2;
    localparam logic [31:0]    c_Y_BASE = 32'(N_IN + 2);
    localparam logic [31:0]    c_Y_END  = 32'(N_IN + N_OUT + 2);
    localparam logic [TCW-1:0] c_T_LAST = TCW'(TIMEOUT - 1);
    localparam logic [0:0]     c_IDLE   = 1'b0;
    localparam logic [0:0]     c_RUN    = 1'b1;

    logic [0:0]     r_state;
    logic [0:0]     w_state_nxt;
    logic [TCW-1:0] r_tcnt;
    logic [15:0]    r_cycles;
    logic           r_irq_en, r_done, r_to, r_err, r_start;
    logic [31:0]    r_rdata;
    logic [31:0]    r_x [N_IN];
    logic [31:0]    r_y [N_OUT];

    logic [31:0]    w_addr, w_rdata;
    logic [XIW-1:0] w_xidx;
    logic [YIW-1:0] w_yidx;
    logic           w_wr, w_rd, w_is_x, w_is_y;
    logic           w_ctrl_wr, w_stat_wr, w_x_wr, w_start_req, w_clr_req;
    logic           w_busy, w_enter, w_done_evt, w_to_evt, w_err_evt;

    assign w_addr      = 32'(AVL_ADDR);
    assign w_wr        = AVL_CS & AVL_WRITE;
    assign w_rd        = AVL_CS & AVL_READ;
    assign w_is_x      = (w_addr >= c_X_BASE) && (w_addr < c_Y_BASE);
    assign w_is_y      = (w_addr >= c_Y_BASE) && (w_addr < c_Y_END);
    assign w_xidx      = XIW'(w_addr - c_X_BASE);
    assign w_yidx      = YIW'(w_addr - c_Y_BASE);
    assign w_ctrl_wr   = w_wr && (w_addr == 32'd0);
    assign w_stat_wr   = w_wr && (w_addr == 32'd1);
    assign w_x_wr      = w_wr && w_is_x;
    assign w_start_req = w_ctrl_wr && AVL_BYTE_EN[0] && AVL_WRITEDATA[0];
    assign w_clr_req   = w_ctrl_wr && AVL_BYTE_EN[0] && AVL_WRITEDATA[1];

    // FSM state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= c_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next-state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_start_req) w_state_nxt = c_RUN;
            c_RUN:   if (NN_DONE || (r_tcnt == c_T_LAST)) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // FSM outputs / event strobes; completion takes priority over timeout
    always_comb begin
        w_busy     = (r_state == c_RUN);
        w_enter    = (r_state == c_IDLE) && w_start_req;
        w_done_evt = w_busy && NN_DONE;
        w_to_evt   = w_busy && !NN_DONE && (r_tcnt == c_T_LAST);
        w_err_evt  = w_busy && (w_x_wr || w_start_req || w_clr_req);
    end

    always_comb begin
        w_rdata = '0;
        if (w_addr == 32'd0)      w_rdata = {29'd0, r_irq_en, 2'b00};
        else if (w_addr == 32'd1) w_rdata = {r_cycles, 12'd0, r_err, r_to, r_done, w_busy};
        else if (w_is_x)          w_rdata = r_x[w_xidx];
        else if (w_is_y)          w_rdata = r_y[w_yidx];
    end

    // Control/status; hardware set beats a same-cycle W1C
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_start  <= 1'b0;
            r_tcnt   <= '0;
            r_cycles <= '0;
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_to     <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_start <= w_enter;
            if (w_enter) begin
                r_tcnt   <= '0;
                r_cycles <= '0;
            end else if (w_busy && !w_done_evt && !w_to_evt) begin
                r_tcnt <= r_tcnt + 1'b1;
                if (r_cycles != 16'hFFFF) r_cycles <= r_cycles + 16'd1;
            end
            if (w_ctrl_wr && AVL_BYTE_EN[0]) r_irq_en <= AVL_WRITEDATA[2];
            if (w_enter)                              r_done <= 1'b0;
            else if (w_done_evt)                      r_done <= 1'b1;
            else if (w_stat_wr && AVL_WRITEDATA[1])   r_done <= 1'b0;
            if (w_enter)                              r_to <= 1'b0;
            else if (w_to_evt)                        r_to <= 1'b1;
            else if (w_stat_wr && AVL_WRITEDATA[2])   r_to <= 1'b0;
            if (w_err_evt)                            r_err <= 1'b1;
            else if (w_stat_wr && AVL_WRITEDATA[3])   r_err <= 1'b0;
            if (w_rd) r_rdata <= w_rdata;
        end
    end

    // Input words are writable only while idle, so the core sees stable X
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < N_IN; i++) r_x[i] <= '0;
        end else if (!w_busy) begin
            if (w_clr_req) begin
                for (int i = 0; i < N_IN; i++) r_x[i] <= '0;
            end else if (w_x_wr) begin
                for (int b = 0; b < 4; b++)
                    if (AVL_BYTE_EN[b]) r_x[w_xidx][8*b +: 8] <= AVL_WRITEDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int j = 0; j < N_OUT; j++) r_y[j] <= '0;
        end else if (w_done_evt) begin
            for (int j = 0; j < N_OUT; j++) r_y[j] <= NN_Y[32*j +: 32];
        end
    end

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_nn_x
            assign NN_X[32*gi +: 32] = r_x[gi];
        end
    endgenerate

    assign AVL_READDATA = r_rdata;
    assign NN_START     = r_start;
    assign IRQ          = r_done & r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_avalon_nn_ctrl_interface.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_nn_ctrl_interface
// Brief    : Self-checking bench with vector table, directed runs and random runs
// Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_nn_ctrl_interface;
    localparam int N_IN    = 8;
    localparam int N_OUT   = 4;
    localparam int AW      = 4;
    localparam int TIMEOUT = 32;
    localparam int N_ADDR  = 1 << AW;

    logic                 CLK = 1'b0;
    logic                 RESET = 1'b1;
    logic                 AVL_READ = 1'b0, AVL_WRITE = 1'b0, AVL_CS = 1'b0;
    logic [3:0]           AVL_BYTE_EN = '0;
    logic [AW-1:0]        AVL_ADDR = '0;
    logic [31:0]          AVL_WRITEDATA = '0;
    logic [31:0]          AVL_READDATA;
    logic                 IRQ;
    logic [32*N_IN-1:0]   NN_X;
    logic                 NN_START;
    logic [32*N_OUT-1:0]  NN_Y = '0;
    logic                 NN_DONE = 1'b0;

    avalon_nn_ctrl_interface #(.N_IN(N_IN), .N_OUT(N_OUT), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RESET(RESET), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
        .AVL_CS(AVL_CS), .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR),
        .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA), .IRQ(IRQ),
        .NN_X(NN_X), .NN_START(NN_START), .NN_Y(NN_Y), .NN_DONE(NN_DONE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    always @(posedge CLK) if (NN_START) start_cnt <= start_cnt + 1;

    // Reference model of the software-visible state
    logic [31:0] mx [N_IN];
    logic [31:0] my [N_OUT];
    logic        mirq, mdone, mto, merr;
    logic [15:0] mcyc;

    typedef struct {
        int          addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;
    vec_t tv [11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N_IN; i++) mx[i] = '0;
        for (int j = 0; j < N_OUT; j++) my[j] = '0;
        mirq = 0; mdone = 0; mto = 0; merr = 0; mcyc = '0;
    endfunction

    function automatic void model_write(input int a, input logic [31:0] d, input logic [3:0] be, input bit busy);
        if (a == 0) begin
            if (be[0]) begin
                mirq = d[2];
                if (busy && (d[0] || d[1])) merr = 1;
                else if (!busy && d[1]) for (int i = 0; i < N_IN; i++) mx[i] = '0;
            end
        end else if (a == 1) begin
            if (d[1]) mdone = 0;
            if (d[2]) mto = 0;
            if (d[3]) merr = 0;
        end else if (a >= 2 && a < N_IN + 2) begin
            if (busy) merr = 1;
            else for (int b = 0; b < 4; b++) if (be[b]) mx[a-2][8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    function automatic logic [31:0] model_read(input int a);
        if (a == 0) return {29'd0, mirq, 2'b00};
        if (a == 1) return {mcyc, 12'd0, merr, mto, mdone, 1'b0};
        if (a >= 2 && a < N_IN + 2) return mx[a-2];
        if (a >= N_IN + 2 && a < N_IN + N_OUT + 2) return my[a-N_IN-2];
        return 32'd0;
    endfunction

    function automatic void bus_idle();
        AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0; AVL_BYTE_EN = '0;
    endfunction

    function automatic void drive_wr(input int a, input logic [31:0] d, input logic [3:0] be);
        AVL_CS = 1; AVL_WRITE = 1; AVL_READ = 0;
        AVL_ADDR = AW'(a); AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    endfunction

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
        drive_wr(a, d, be);
        @(posedge CLK); #1;
        bus_idle();
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        AVL_CS = 1; AVL_READ = 1; AVL_WRITE = 0; AVL_ADDR = AW'(a);
        @(posedge CLK); #1;
        bus_idle();
        d = AVL_READDATA;
    endtask

    task automatic verify_all(input string tag);
        logic [31:0] r;
        for (int a = 0; a < N_ADDR; a++) begin
            rd(a, r);
            check($sformatf("%s_rd%0d", tag, a), r, model_read(a));
        end
        check({tag, "_irq"}, {31'd0, IRQ}, {31'd0, mdone & mirq});
        for (int i = 0; i < N_IN; i++)
            check($sformatf("%s_nnx%0d", tag, i), NN_X[32*i +: 32], mx[i]);
    endtask

    // One inference; core answers d cycles after NN_START (never if d >= TIMEOUT)
    task automatic run_inf(input int d, input logic [32*N_OUT-1:0] yv, input bit irq_en, input bit inject);
        int  s0, exit_k;
        bit  rd_last;
        exit_k  = (d < TIMEOUT - 1) ? d : TIMEOUT - 1;
        rd_last = 0;
        s0      = start_cnt;
        wr(0, irq_en ? 32'h5 : 32'h1, 4'h1);
        mirq = irq_en; mdone = 0; mto = 0;
        check("nn_start_first", {31'd0, NN_START}, 32'd1);
        for (int k = 0; k <= exit_k; k++) begin
            bus_idle();
            NN_DONE = 0;
            if (k == d) begin NN_DONE = 1; NN_Y = yv; end
            if (inject && k == 1) begin
                drive_wr(7, 32'hFFFF_FFFF, 4'hF);
                model_write(7, 32'hFFFF_FFFF, 4'hF, 1);
            end else if (inject && k == 2) begin
                drive_wr(0, irq_en ? 32'h7 : 32'h3, 4'h1);
                model_write(0, irq_en ? 32'h7 : 32'h3, 4'h1, 1);
            end else if (k == exit_k) begin
                AVL_CS = 1; AVL_READ = 1; AVL_ADDR = AW'(1); rd_last = 1;
            end
            @(posedge CLK); #1;
            if (k == 0) check("nn_start_one_cycle", {31'd0, NN_START}, 32'd0);
        end
        bus_idle();
        NN_DONE = 0;
        if (rd_last) check("busy_last_run_cycle", {31'd0, AVL_READDATA[0]}, 32'd1);
        check("start_pulses", 32'(start_cnt - s0), 32'd1);
        if (d <= TIMEOUT - 1) begin
            mdone = 1;
            for (int j = 0; j < N_OUT; j++) my[j] = yv[32*j +: 32];
        end else begin
            mto = 1;
        end
        mcyc = 16'(exit_k);
        // Completion seen while idle must be ignored
        NN_Y = ~yv; NN_DONE = 1;
        @(posedge CLK); #1;
        NN_DONE = 0;
        verify_all("run");
    endtask

    initial begin
        logic [31:0]         r;
        logic [32*N_OUT-1:0] yv, yv2;
        int                  a, d;
        logic [31:0]         wd;
        logic [3:0]          be;

        tv[0]  = '{2,  32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
        tv[1]  = '{2,  32'h00005500, 4'h2, 32'hDEAD55EF};
        tv[2]  = '{9,  32'h12345678, 4'h9, 32'h12000078};
        tv[3]  = '{5,  32'h00AB0000, 4'h4, 32'h00AB0000};
        tv[4]  = '{0,  32'hFFFFFFF4, 4'hF, 32'h00000004};
        tv[5]  = '{0,  32'h00000000, 4'hE, 32'h00000004};
        tv[6]  = '{0,  32'h00000000, 4'h1, 32'h00000000};
        tv[7]  = '{14, 32'hFFFFFFFF, 4'hF, 32'h00000000};
        tv[8]  = '{15, 32'hFFFFFFFF, 4'hF, 32'h00000000};
        tv[9]  = '{10, 32'hFFFFFFFF, 4'hF, 32'h00000000};
        tv[10] = '{1,  32'hFFFFFFFF, 4'hF, 32'h00000000};

        model_reset();
        bus_idle();
        repeat (3) @(posedge CLK);
        #1;
        check("rst_nn_start", {31'd0, NN_START}, 32'd0);
        check("rst_irq", {31'd0, IRQ}, 32'd0);
        check("rst_readdata", AVL_READDATA, 32'd0);
        RESET = 0;
        verify_all("post_reset");

        for (int i = 0; i < 11; i++) begin
            wr(tv[i].addr, tv[i].wdata, tv[i].be);
            model_write(tv[i].addr, tv[i].wdata, tv[i].be, 0);
            rd(tv[i].addr, r);
            check($sformatf("vec%0d", i), r, tv[i].exp);
            if (i == 1) begin
                AVL_CS = 1; AVL_ADDR = AW'(0);
                @(posedge CLK); #1;
                check("rd_hold_noread", AVL_READDATA, 32'hDEAD55EF);
                AVL_CS = 0; AVL_READ = 1;
                @(posedge CLK); #1;
                bus_idle();
                check("rd_hold_nocs", AVL_READDATA, 32'hDEAD55EF);
            end
        end
        verify_all("table");

        wr(0, 32'h2, 4'h1);
        model_write(0, 32'h2, 4'h1, 0);
        verify_all("clr_in");

        // Reset in the middle of a run
        wr(3, 32'hA5A5A5A5, 4'hF);
        wr(6, 32'h0F0F0F0F, 4'hF);
        wr(0, 32'h5, 4'h1);
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1;
        #1;
        check("midrun_rst_nn_start", {31'd0, NN_START}, 32'd0);
        check("midrun_rst_irq", {31'd0, IRQ}, 32'd0);
        check("midrun_rst_nnx", NN_X[31:0] | NN_X[32*4 +: 32], 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 0;
        model_reset();
        NN_Y = '1; NN_DONE = 1;
        @(posedge CLK); #1;
        NN_DONE = 0;
        verify_all("midrun_rst");

        // Completion after 10 cycles with interrupt enabled
        yv = '0;
        yv[31:0] = 32'h12;
        for (int j = 1; j < N_OUT; j++) yv[32*j +: 32] = $urandom;
        run_inf(10, yv, 1, 0);
        rd(1, r);
        check("done_status", r, 32'h000A0002);
        rd(N_IN + 2, r);
        check("done_y0", r, 32'h12);
        check("done_irq_set", {31'd0, IRQ}, 32'd1);
        wr(1, 32'h2, 4'hF);
        model_write(1, 32'h2, 4'hF, 0);
        check("done_irq_clr", {31'd0, IRQ}, 32'd0);

        // Locked X plus done coinciding with the timeout cycle
        wr(7, 32'h55AA55AA, 4'hF);
        model_write(7, 32'h55AA55AA, 4'hF, 0);
        for (int j = 0; j < N_OUT; j++) yv2[32*j +: 32] = $urandom;
        run_inf(TIMEOUT - 1, yv2, 1, 1);
        rd(1, r);
        check("lock_status_bits", r & 32'hE, 32'hA);
        check("lock_x5", NN_X[32*5 +: 32], 32'h55AA55AA);
        wr(1, 32'hE, 4'hF);
        model_write(1, 32'hE, 4'hF, 0);

        // Core never answers
        run_inf(TIMEOUT + 3, ~yv2, 0, 0);
        rd(1, r);
        check("timeout_status", r, {16'(TIMEOUT - 1), 16'h0004});
        rd(N_IN + 2, r);
        check("timeout_y0_held", r, yv2[31:0]);

        // Random register traffic while idle
        for (int n = 0; n < 30; n++) begin
            a  = $urandom_range(0, N_ADDR - 1);
            wd = $urandom;
            be = 4'($urandom_range(0, 15));
            if (a == 0) wd[0] = 1'b0;
            wr(a, wd, be);
            model_write(a, wd, be, 0);
        end
        verify_all("rand_wr");

        // Random inferences
        for (int n = 0; n < 5; n++) begin
            d = $urandom_range(2, TIMEOUT + 4);
            for (int j = 0; j < N_OUT; j++) yv[32*j +: 32] = $urandom;
            run_inf(d, yv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wr(1, 32'hE, 4'hF);
            model_write(1, 32'hE, 4'hF, 0);
        end
        verify_all("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
